snn_mac_accum: RTL and testbench

Sequential, parametrised successor to the combinational five-tap spike MAC in the layer-1/layer-2 datapath. Each accepted beat sums the signed weights of the active spike inputs. Beats are accumulated over a frame of `FRAME_LEN` beats, with saturation, into a wide signed membrane sum. That sum is delivered through a valid/ready handshake to the neuron threshold stage.

---
 rtl/snn_pkg.sv | 24 ++
 rtl/snn_tap_sum.sv | 24 ++
 rtl/snn_mac_accum.sv | 153 +++++++++++++++
 tb/tb_snn_mac_accum.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and helpers for the spike MAC accumulator: FSM states,
// partial-sum width derivation and width-parametrised saturation limits.
package snn_pkg;

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   // Width that holds the sum of n_taps signed weights without overflow.
   function automatic int psum_width(input int n_taps, input int w_width);
      return w_width + $clog2(n_taps);
   endfunction

   function automatic logic signed [63:0] sat_max(input int width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_min(input int width);
      return -(64'sd1 <<< (width - 1));
   endfunction

endpackage

// File: rtl/snn_tap_sum.sv
// Combinational gated adder: sums the sign-extended weights of the taps
// whose spike bit is set, at a width that cannot overflow.
module snn_tap_sum
   import snn_pkg::*;
#(
   parameter int N_TAPS     = 5,
   parameter int W_WIDTH    = 8,
   parameter int PSUM_WIDTH = psum_width(N_TAPS, W_WIDTH)
) (
   input  logic [N_TAPS-1:0]          spikes,
   input  logic [N_TAPS*W_WIDTH-1:0]  weights,
   output logic signed [PSUM_WIDTH-1:0] psum
);

   always_comb begin
      psum = '0;
      for (int i = 0; i < N_TAPS; i++) begin
         if (spikes[i]) begin
            psum = psum + PSUM_WIDTH'(signed'(weights[i*W_WIDTH +: W_WIDTH]));
         end
      end
   end

endmodule

// File: rtl/snn_mac_accum.sv
// Frame accumulator: registers each beat's tap sum, accumulates it with
// saturation over FRAME_LEN beats and hands the frame sum out via valid/ready.
module snn_mac_accum
   import snn_pkg::*;
#(
   parameter int N_TAPS    = 5,
   parameter int W_WIDTH   = 8,
   parameter int ACC_WIDTH = 16,
   parameter int FRAME_LEN = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [N_TAPS-1:0]           spikes,
   input  logic [N_TAPS*W_WIDTH-1:0]   weights,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [ACC_WIDTH-1:0] out_sum,
   output logic                        out_sat
);

   localparam int PSUM_W = psum_width(N_TAPS, W_WIDTH);
   localparam int SUM_W  = ACC_WIDTH + 1;
   localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(sat_max(ACC_WIDTH));
   localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(sat_min(ACC_WIDTH));
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

   state_e                      state_q, state_d;
   logic [CNT_W-1:0]            beat_cnt_q, beat_cnt_d;
   logic signed [PSUM_W-1:0]    psum_q, psum_d;
   logic                        psum_v_q, psum_v_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                        sat_flag_q, sat_flag_d;
   logic signed [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
   logic                        out_sat_q, out_sat_d;
   logic                        out_valid_q, out_valid_d;

   logic signed [PSUM_W-1:0]    beat_sum;
   logic signed [SUM_W-1:0]     sum_raw;
   logic                        clamp_hi, clamp_lo;
   logic signed [ACC_WIDTH-1:0] sat_val;
   logic                        accept;

   snn_tap_sum #(
      .N_TAPS     (N_TAPS),
      .W_WIDTH    (W_WIDTH),
      .PSUM_WIDTH (PSUM_W)
   ) u_tap_sum (
      .spikes  (spikes),
      .weights (weights),
      .psum    (beat_sum)
   );

   // One extra bit of headroom makes the clamp test exact.
   assign sum_raw  = SUM_W'(acc_q) + SUM_W'(psum_q);
   assign clamp_hi = sum_raw > SAT_HI;
   assign clamp_lo = sum_raw < SAT_LO;
   assign sat_val  = clamp_hi ? SAT_HI[ACC_WIDTH-1:0] :
                     clamp_lo ? SAT_LO[ACC_WIDTH-1:0] : sum_raw[ACC_WIDTH-1:0];

   assign in_ready  = (state_q == ST_ACCUM);
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_sat   = out_sat_q;

   always_comb begin
      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      psum_d      = psum_q;
      psum_v_d    = 1'b0;
      acc_d       = acc_q;
      sat_flag_d  = sat_flag_q;
      out_sum_d   = out_sum_q;
      out_sat_d   = out_sat_q;
      out_valid_d = out_valid_q;

      if (psum_v_q) begin
         acc_d = sat_val;
         if (clamp_hi || clamp_lo) sat_flag_d = 1'b1;
      end

      unique case (state_q)
         ST_ACCUM: begin
            if (accept) begin
               psum_d   = beat_sum;
               psum_v_d = 1'b1;
               if (beat_cnt_q == LAST_BEAT) begin
                  beat_cnt_d = '0;
                  state_d    = ST_FLUSH;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         ST_FLUSH: begin
            out_sum_d = sat_val;
            out_sat_d = sat_flag_q | clamp_hi | clamp_lo;
            state_d   = ST_HOLD;
         end
         ST_HOLD: begin
            // out_valid rises one cycle into HOLD and drops on the handshake.
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_ACCUM;
               acc_d       = '0;
               sat_flag_d  = 1'b0;
               beat_cnt_d  = '0;
            end
         end
         default: state_d = ST_ACCUM;
      endcase

      if (clr) begin
         state_d     = ST_ACCUM;
         acc_d       = '0;
         beat_cnt_d  = '0;
         sat_flag_d  = 1'b0;
         psum_v_d    = 1'b0;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_ACCUM;
         beat_cnt_q  <= '0;
         psum_q      <= '0;
         psum_v_q    <= 1'b0;
         acc_q       <= '0;
         sat_flag_q  <= 1'b0;
         out_sum_q   <= '0;
         out_sat_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_cnt_q  <= beat_cnt_d;
         psum_q      <= psum_d;
         psum_v_q    <= psum_v_d;
         acc_q       <= acc_d;
         sat_flag_q  <= sat_flag_d;
         out_sum_q   <= out_sum_d;
         out_sat_q   <= out_sat_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_snn_mac_accum.sv
// Directed bench for snn_mac_accum: a 16-bit and a 12-bit accumulator share
// all inputs and run in lockstep; each scenario task checks its own results.
module tb_snn_mac_accum;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic        in_valid;
   logic [4:0]  spikes;
   logic [39:0] weights;
   logic        out_ready;

   logic               a_in_ready, a_out_valid, a_out_sat;
   logic signed [15:0] a_out_sum;
   logic               b_in_ready, b_out_valid, b_out_sat;
   logic signed [11:0] b_out_sum;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   snn_mac_accum #(.N_TAPS(5), .W_WIDTH(8), .ACC_WIDTH(16), .FRAME_LEN(4)) u_dut (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(a_in_ready),
      .spikes(spikes), .weights(weights), .out_valid(a_out_valid),
      .out_ready(out_ready), .out_sum(a_out_sum), .out_sat(a_out_sat)
   );

   snn_mac_accum #(.N_TAPS(5), .W_WIDTH(8), .ACC_WIDTH(12), .FRAME_LEN(4)) u_dut12 (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(b_in_ready),
      .spikes(spikes), .weights(weights), .out_valid(b_out_valid),
      .out_ready(out_ready), .out_sum(b_out_sum), .out_sat(b_out_sat)
   );

   // which=0 observes the 16-bit instance, which=1 the 12-bit one.
   task automatic run_frame(input int which, input logic [4:0] spk, input logic [39:0] wts,
                            input int exp_sum, input logic exp_sat, input int stall,
                            input string name);
      logic               rdy, vld, sat;
      logic signed [15:0] sum, exp16;
      exp16    = 16'(exp_sum);
      spikes   = spk;
      weights  = wts;
      in_valid = 1'b1;
      for (int b = 0; b < 4; b++) begin
         rdy = which ? b_in_ready : a_in_ready;
         checks++;
         if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL %s beat%0d in_ready: got %b want 1", name, b, rdy);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rdy = which ? b_in_ready : a_in_ready;
      vld = which ? b_out_valid : a_out_valid;
      checks++;
      if (rdy !== 1'b0 || vld !== 1'b0) begin
         failures++;
         $display("FAIL %s after_e0: in_ready=%b out_valid=%b want 0/0", name, rdy, vld);
      end
      @(posedge clk); #1;
      vld = which ? b_out_valid : a_out_valid;
      checks++;
      if (vld !== 1'b0) begin
         failures++;
         $display("FAIL %s after_e1 out_valid: got %b want 0", name, vld);
      end
      @(posedge clk); #1;
      for (int c = 0; c <= stall; c++) begin
         rdy = which ? b_in_ready : a_in_ready;
         vld = which ? b_out_valid : a_out_valid;
         sum = which ? 16'(b_out_sum) : a_out_sum;
         sat = which ? b_out_sat : a_out_sat;
         checks++;
         if (vld !== 1'b1 || rdy !== 1'b0) begin
            failures++;
            $display("FAIL %s hold%0d valid/ready: got %b/%b want 1/0", name, c, vld, rdy);
         end
         checks++;
         if (sum !== exp16 || sat !== exp_sat) begin
            failures++;
            $display("FAIL %s hold%0d sum/sat: got %0d/%b want %0d/%b",
                     name, c, sum, sat, exp16, exp_sat);
         end
         if (c < stall) begin
            @(posedge clk); #1;
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      rdy = which ? b_in_ready : a_in_ready;
      vld = which ? b_out_valid : a_out_valid;
      sum = which ? 16'(b_out_sum) : a_out_sum;
      checks++;
      if (vld !== 1'b0 || rdy !== 1'b1 || sum !== exp16) begin
         failures++;
         $display("FAIL %s handshake: valid=%b ready=%b sum=%0d want 0/1/%0d",
                  name, vld, rdy, sum, exp16);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      spikes = '0; weights = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_sum !== 16'sd0 || a_out_sat !== 1'b0) begin
         failures++;
         $display("FAIL reset_a: ready=%b valid=%b sum=%0d sat=%b want 1/0/0/0",
                  a_in_ready, a_out_valid, a_out_sum, a_out_sat);
      end
      checks++;
      if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_out_sum !== 12'sd0 || b_out_sat !== 1'b0) begin
         failures++;
         $display("FAIL reset_b: ready=%b valid=%b sum=%0d sat=%b want 1/0/0/0",
                  b_in_ready, b_out_valid, b_out_sum, b_out_sat);
      end
   endtask

   task automatic test_basic_sum();
      run_frame(0, 5'b11111, 40'h01_01_01_01_01, 20, 1'b0, 0, "ones");
   endtask

   task automatic test_signed_weights();
      run_frame(0, 5'b10101, 40'h7F_80_07_FD_0A, 576, 1'b0, 0, "signed_pos");
      run_frame(0, 5'b01010, 40'h7F_80_07_FD_0A, -524, 1'b0, 0, "signed_neg");
   endtask

   task automatic test_saturation();
      run_frame(1, 5'b11111, 40'h7F_7F_7F_7F_7F, 2047, 1'b1, 0, "sat_hi");
      run_frame(1, 5'b11111, 40'h80_80_80_80_80, -2048, 1'b1, 0, "sat_lo");
      run_frame(1, 5'b11111, 40'h01_01_01_01_01, 20, 1'b0, 0, "sat_clean");
      run_frame(0, 5'b11111, 40'h7F_7F_7F_7F_7F, 2540, 1'b0, 0, "wide_no_sat");
   endtask

   task automatic test_back_to_back();
      run_frame(0, 5'b11111, 40'h01_01_01_01_01, 20, 1'b0, 10, "stall");
      run_frame(0, 5'b10101, 40'h7F_80_07_FD_0A, 576, 1'b0, 0, "after_stall");
   endtask

   task automatic test_gaps();
      logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      spikes  = 5'b11111;
      weights = 40'h02_02_02_02_02;
      for (int k = 0; k < 7; k++) begin
         in_valid = pat[k];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0) begin
         failures++;
         $display("FAIL gaps_e0: ready=%b valid=%b want 0/0", a_in_ready, a_out_valid);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_sum !== 16'sd40 || a_out_sat !== 1'b0) begin
         failures++;
         $display("FAIL gaps_result: valid=%b sum=%0d sat=%b want 1/40/0",
                  a_out_valid, a_out_sum, a_out_sat);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_rst_clr();
      spikes   = 5'b11111;
      weights  = 40'h05_05_05_05_05;
      in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1 in_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_sum !== 16'sd0 || a_out_sat !== 1'b0) begin
         failures++;
         $display("FAIL mid_rst: ready=%b valid=%b sum=%0d sat=%b want 1/0/0/0",
                  a_in_ready, a_out_valid, a_out_sum, a_out_sat);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1 clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_sum !== 16'sd0 || a_out_sat !== 1'b0) begin
         failures++;
         $display("FAIL after_clr: ready=%b valid=%b sum=%0d sat=%b want 1/0/0/0",
                  a_in_ready, a_out_valid, a_out_sum, a_out_sat);
      end
      run_frame(0, 5'b11111, 40'h01_01_01_01_01, 20, 1'b0, 0, "post_clr");
   endtask

   initial begin
      test_reset();
      test_basic_sum();
      test_signed_weights();
      test_saturation();
      test_back_to_back();
      test_gaps();
      test_rst_clr();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
